// File: rtl/rv32i_pkg.sv
// Shared opcode/funct3 encodings, ALU and writeback selectors for the RV32I single-cycle core.
package rv32i_pkg;

  localparam logic [6:0] OP       = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] LOAD     = 7'b0000011;
  localparam logic [6:0] STORE    = 7'b0100011;
  localparam logic [6:0] BRANCH   = 7'b1100011;
  localparam logic [6:0] JAL      = 7'b1101111;
  localparam logic [6:0] JALR     = 7'b1100111;
  localparam logic [6:0] LUI      = 7'b0110111;
  localparam logic [6:0] AUIPC    = 7'b0010111;
  localparam logic [6:0] SYSTEM   = 7'b1110011;
  localparam logic [6:0] MISC_MEM = 7'b0001111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  localparam logic [1:0] MW_NONE = 2'b00;
  localparam logic [1:0] MW_B    = 2'b01;
  localparam logic [1:0] MW_H    = 2'b10;
  localparam logic [1:0] MW_W    = 2'b11;

  localparam int unsigned REG_COUNT = 32;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
  } alu_op_t;

  typedef enum logic [1:0] {WB_ALU, WB_PC4, WB_LOAD} wb_sel_t;

  // alt selects SUB for funct3=000 and SRA for funct3=101
  function automatic alu_op_t alu_decode(input logic [2:0] f3, input logic alt);
    alu_op_t op;
    case (f3)
      F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  op = ALU_SLL;
      F3_SLT:  op = ALU_SLT;
      F3_SLTU: op = ALU_SLTU;
      F3_XOR:  op = ALU_XOR;
      F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:   op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rv32i_regfile.sv
// 32x32 integer register file: two async read ports, one sync write port, x0 hardwired to zero.
module rv32i_regfile
  import rv32i_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  input  logic [4:0]  rd_addr,
  input  logic        we,
  input  logic [31:0] wd,
  output logic [31:0] rs1_val,
  output logic [31:0] rs2_val
);

  logic [31:0] Registers [REG_COUNT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < REG_COUNT; i++) Registers[i] <= '0;
    end else if (we && rd_addr != 5'd0) begin
      Registers[rd_addr] <= wd;
    end
  end

  assign rs1_val = (rs1_addr == 5'd0) ? '0 : Registers[rs1_addr];
  assign rs2_val = (rs2_addr == 5'd0) ? '0 : Registers[rs2_addr];

endmodule

// File: rtl/rv32i_single_cycle_core.sv
// Single-cycle RV32I core: decode, immediates, ALU and next-pc logic; memories are external.
// Optional HALT_ON_ECALL_EN: ECALL/EBREAK freeze the core until reset.
module rv32i_single_cycle_core
  import rv32i_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] instruction,
  input  logic [XLEN-1:0] data,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] rd_data,
  output logic [XLEN-1:0] Read_data_2,
  output logic            MemREAD,
  output logic [1:0]      MemWrite
);

  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_val, rs2_val, alu_a, alu_b, alu_y;
  logic [31:0] pc_plus4, pc_next, wb_val, load_val, jalr_target;
  alu_op_t     alu_op;
  wb_sel_t     wb_sel;
  logic        reg_we, mem_read, br_taken, stall;
  logic [1:0]  mem_write;

  assign opcode = instruction[6:0];
  assign rd     = instruction[11:7];
  assign funct3 = instruction[14:12];
  assign rs1    = instruction[19:15];
  assign rs2    = instruction[24:20];
  assign funct7 = instruction[31:25];

  assign imm_i = {{20{instruction[31]}}, instruction[31:20]};
  assign imm_s = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
  assign imm_b = {{19{instruction[31]}}, instruction[31], instruction[7],
                  instruction[30:25], instruction[11:8], 1'b0};
  assign imm_u = {instruction[31:12], 12'b0};
  assign imm_j = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                  instruction[20], instruction[30:21], 1'b0};

  rv32i_regfile u_regfile (
    .clk      (clk),
    .rst      (rst),
    .rs1_addr (rs1),
    .rs2_addr (rs2),
    .rd_addr  (rd),
    .we       (reg_we && !stall),
    .wd       (wb_val),
    .rs1_val  (rs1_val),
    .rs2_val  (rs2_val)
  );

  assign pc_plus4    = pc + 32'd4;
  assign jalr_target = (rs1_val + imm_i) & ~32'd1;

  always_comb begin
    case (funct3)
      F3_BEQ:  br_taken = (rs1_val == rs2_val);
      F3_BNE:  br_taken = (rs1_val != rs2_val);
      F3_BLT:  br_taken = ($signed(rs1_val) <  $signed(rs2_val));
      F3_BGE:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
      F3_BLTU: br_taken = (rs1_val <  rs2_val);
      F3_BGEU: br_taken = (rs1_val >= rs2_val);
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    case (funct3)
      F3_LB:   load_val = {{24{data[7]}}, data[7:0]};
      F3_LH:   load_val = {{16{data[15]}}, data[15:0]};
      F3_LBU:  load_val = {24'b0, data[7:0]};
      F3_LHU:  load_val = {16'b0, data[15:0]};
      default: load_val = data;
    endcase
  end

  always_comb begin
    case (alu_op)
      ALU_ADD:  alu_y = alu_a + alu_b;
      ALU_SUB:  alu_y = alu_a - alu_b;
      ALU_SLL:  alu_y = alu_a << alu_b[4:0];
      ALU_SLT:  alu_y = {31'b0, $signed(alu_a) < $signed(alu_b)};
      ALU_SLTU: alu_y = {31'b0, alu_a < alu_b};
      ALU_XOR:  alu_y = alu_a ^ alu_b;
      ALU_SRL:  alu_y = alu_a >> alu_b[4:0];
      ALU_SRA:  alu_y = $unsigned($signed(alu_a) >>> alu_b[4:0]);
      ALU_OR:   alu_y = alu_a | alu_b;
      ALU_AND:  alu_y = alu_a & alu_b;
      default:  alu_y = alu_b;
    endcase
  end

`ifdef HALT_ON_ECALL_EN
  logic halt_req;
`endif

  // Anything not explicitly recognised falls through the defaults and retires as a NOP.
  always_comb begin
    alu_op    = ALU_ADD;
    alu_a     = rs1_val;
    alu_b     = imm_i;
    wb_sel    = WB_ALU;
    reg_we    = 1'b0;
    mem_read  = 1'b0;
    mem_write = MW_NONE;
    pc_next   = pc_plus4;
`ifdef HALT_ON_ECALL_EN
    halt_req  = 1'b0;
`endif
    case (opcode)
      LUI: begin
        alu_op = ALU_PASS_B;
        alu_b  = imm_u;
        reg_we = 1'b1;
      end
      AUIPC: begin
        alu_a  = pc;
        alu_b  = imm_u;
        reg_we = 1'b1;
      end
      JAL: begin
        wb_sel  = WB_PC4;
        reg_we  = 1'b1;
        pc_next = pc + imm_j;
      end
      JALR: if (funct3 == 3'b000) begin
        wb_sel  = WB_PC4;
        reg_we  = 1'b1;
        pc_next = jalr_target;
      end
      BRANCH: begin
        alu_op = ALU_SUB;
        alu_b  = rs2_val;
        if (br_taken) pc_next = pc + imm_b;
      end
      LOAD: if (funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU}) begin
        wb_sel   = WB_LOAD;
        reg_we   = 1'b1;
        mem_read = 1'b1;
      end
      STORE: if (funct3 inside {F3_SB, F3_SH, F3_SW}) begin
        alu_b     = imm_s;
        mem_write = funct3[1:0] + 2'd1;
      end
      OP_IMM: begin
        if (funct3 == F3_SLL) begin
          if (funct7 == 7'h00) begin
            alu_op = ALU_SLL;
            reg_we = 1'b1;
          end
        end else if (funct3 == F3_SR) begin
          if (funct7 == 7'h00 || funct7 == 7'h20) begin
            alu_op = alu_decode(funct3, funct7[5]);
            reg_we = 1'b1;
          end
        end else begin
          alu_op = alu_decode(funct3, 1'b0);
          reg_we = 1'b1;
        end
      end
      OP: if (funct7 == 7'h00 ||
              (funct7 == 7'h20 && (funct3 == F3_ADD || funct3 == F3_SR))) begin
        alu_op = alu_decode(funct3, funct7[5]);
        alu_b  = rs2_val;
        reg_we = 1'b1;
      end
`ifdef HALT_ON_ECALL_EN
      SYSTEM: if (instruction == 32'h0000_0073 || instruction == 32'h0010_0073) begin
        halt_req = 1'b1;
        pc_next  = pc;
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    case (wb_sel)
      WB_PC4:  wb_val = pc_plus4;
      WB_LOAD: wb_val = load_val;
      default: wb_val = alu_y;
    endcase
  end

`ifdef HALT_ON_ECALL_EN
  logic halted;
  always_ff @(posedge clk) begin
    if (rst)           halted <= 1'b0;
    else if (halt_req) halted <= 1'b1;
  end
  assign stall = halted;
`else
  assign stall = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst)         pc <= RESET_PC;
    else if (!stall) pc <= pc_next & ~32'd3;
  end

  assign rd_data     = alu_y;
  assign Read_data_2 = rs2_val;
  assign MemREAD     = mem_read;
  assign MemWrite    = stall ? MW_NONE : mem_write;

endmodule

// File: tb/tb_rv32i_single_cycle_core.sv
// Directed bench: combinational instruction ROM, byte-addressed data RAM written on clk edge.
module tb_rv32i_single_cycle_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instruction, data, pc, rd_data, Read_data_2;
  logic        MemREAD;
  logic [1:0]  MemWrite;

  int errors = 0;
  int checks = 0;

  logic [31:0] rom [0:31];
  logic [7:0]  dmem [0:8191];

  rv32i_single_cycle_core #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk         (clk),
    .rst         (rst),
    .instruction (instruction),
    .data        (data),
    .pc          (pc),
    .rd_data     (rd_data),
    .Read_data_2 (Read_data_2),
    .MemREAD     (MemREAD),
    .MemWrite    (MemWrite)
  );

  always #5 clk = ~clk;

  logic [12:0] a0;
  assign a0 = rd_data[12:0];
  assign instruction = rom[pc[6:2]];
  assign data = {dmem[a0 + 13'd3], dmem[a0 + 13'd2], dmem[a0 + 13'd1], dmem[a0]};

  always @(posedge clk) begin
    if (MemWrite != 2'b00) dmem[a0] <= Read_data_2[7:0];
    if (MemWrite[1])       dmem[a0 + 13'd1] <= Read_data_2[15:8];
    if (MemWrite == 2'b11) begin
      dmem[a0 + 13'd2] <= Read_data_2[23:16];
      dmem[a0 + 13'd3] <= Read_data_2[31:24];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rchk(input string tag, input int idx, input logic [31:0] exp);
    chk(tag, dut.u_regfile.Registers[idx], exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) dmem[i] = 8'h00;
    for (int i = 0; i < 32; i++) rom[i] = 32'h0000_006F;
    rom[0]  = 32'h00A00093; // addi x1,x0,10
    rom[1]  = 32'h01400113; // addi x2,x0,20
    rom[2]  = 32'h002081B3; // add  x3,x1,x2
    rom[3]  = 32'h40218233; // sub  x4,x3,x2
    rom[4]  = 32'h123452B7; // lui  x5,0x12345
    rom[5]  = 32'h00500013; // addi x0,x0,5
    rom[6]  = 32'h00001A37; // lui  x20,0x1
    rom[7]  = 32'h001A2023; // sw   x1,0(x20)
    rom[8]  = 32'h002A2223; // sw   x2,4(x20)
    rom[9]  = 32'h000A2A83; // lw   x21,0(x20)
    rom[10] = 32'h004A2B03; // lw   x22,4(x20)
    rom[11] = 32'h0020A7B3; // slt  x15,x1,x2
    rom[12] = 32'h00113833; // sltu x16,x2,x1
    rom[13] = 32'h00408463; // beq  x1,x4,+8
    rom[14] = 32'h00100313; // addi x6,x0,1 (skipped)
    rom[15] = 32'h00409463; // bne  x1,x4,+8
    rom[16] = 32'h00700393; // addi x7,x0,7
    rom[17] = 32'h00800BEF; // jal  x23,+8
    rom[18] = 32'h00100413; // addi x8,x0,1 (skipped)
    rom[19] = 32'h009B8C67; // jalr x24,9(x23)
    rom[20] = 32'hF8000493; // addi x9,x0,-128
    rom[21] = 32'h009A0423; // sb   x9,8(x20)
    rom[22] = 32'h008A0503; // lb   x10,8(x20)
    rom[23] = 32'h008A4583; // lbu  x11,8(x20)
    rom[24] = 32'h4044D613; // srai x12,x9,4
    rom[25] = 32'h01C4D693; // srli x13,x9,28
    rom[26] = 32'h00000073; // ecall
    rom[27] = 32'h00300713; // addi x14,x0,3
    rom[28] = 32'h00000000; // illegal
    rom[29] = 32'h0000006F; // jal  x0,0

    rst = 1'b1;
    step();
    step();
    chk("reset_pc", pc, 32'h0);
    chk("reset_memwrite", {30'b0, MemWrite}, 32'h0);
    chk("reset_memread", {31'b0, MemREAD}, 32'h0);
    for (int i = 0; i < 32; i++) rchk($sformatf("reset_x%0d", i), i, 32'h0);
    chk("first_alu", rd_data, 32'hA);
    rst = 1'b0;

    step(); chk("pc_04", pc, 32'h04); rchk("addi_x1", 1, 32'hA);
    step(); rchk("addi_x2", 2, 32'h14);
    step(); rchk("add_x3", 3, 32'h1E);
    step(); rchk("sub_x4", 4, 32'hA);
    step(); rchk("lui_x5", 5, 32'h12345000);
    step(); rchk("x0_zero", 0, 32'h0);
    step(); rchk("lui_x20", 20, 32'h1000); chk("pc_1c", pc, 32'h1C);
    chk("sw0_memwrite", {30'b0, MemWrite}, 32'h3);
    chk("sw0_addr", rd_data, 32'h1000);
    chk("sw0_data", Read_data_2, 32'hA);
    chk("sw0_memread", {31'b0, MemREAD}, 32'h0);
    step();
    chk("sw1_memwrite", {30'b0, MemWrite}, 32'h3);
    chk("sw1_addr", rd_data, 32'h1004);
    chk("mem_1000", {dmem[13'h1003], dmem[13'h1002], dmem[13'h1001], dmem[13'h1000]}, 32'hA);
    step();
    chk("mem_1004", {dmem[13'h1007], dmem[13'h1006], dmem[13'h1005], dmem[13'h1004]}, 32'h14);
    chk("lw_memread", {31'b0, MemREAD}, 32'h1);
    chk("lw_memwrite", {30'b0, MemWrite}, 32'h0);
    step(); rchk("lw_x21", 21, 32'hA);
    step(); rchk("lw_x22", 22, 32'h14);
    step(); rchk("slt_x15", 15, 32'h1);
    step(); rchk("sltu_x16", 16, 32'h0); chk("pc_34", pc, 32'h34);
    step(); chk("beq_taken_pc", pc, 32'h3C);
    step(); chk("bne_not_taken_pc", pc, 32'h40);
    step(); rchk("addi_x7", 7, 32'h7); rchk("skipped_x6", 6, 32'h0);
    step(); chk("jal_pc", pc, 32'h4C); rchk("jal_x23", 23, 32'h48);
    step(); chk("jalr_pc", pc, 32'h50); rchk("jalr_x24", 24, 32'h50); rchk("skipped_x8", 8, 32'h0);
    step(); rchk("addi_neg_x9", 9, 32'hFFFFFF80);
    chk("sb_memwrite", {30'b0, MemWrite}, 32'h1);
    chk("sb_addr", rd_data, 32'h1008);
    step();
    chk("mem_1008", {24'b0, dmem[13'h1008]}, 32'h80);
    chk("mem_1009", {24'b0, dmem[13'h1009]}, 32'h0);
    step(); rchk("lb_x10", 10, 32'hFFFFFF80);
    step(); rchk("lbu_x11", 11, 32'h80);
    step(); rchk("srai_x12", 12, 32'hFFFFFFF8);
    step(); rchk("srli_x13", 13, 32'hF); chk("pc_68", pc, 32'h68);

`ifdef HALT_ON_ECALL_EN
    for (int i = 0; i < 100; i++) step();
    chk("halt_pc", pc, 32'h68);
    chk("halt_memwrite", {30'b0, MemWrite}, 32'h0);
    rchk("halt_x14", 14, 32'h0);
    rchk("halt_x13", 13, 32'hF);
`else
    step(); chk("ecall_nop_pc", pc, 32'h6C);
    step(); rchk("addi_x14", 14, 32'h3);
    chk("illegal_memwrite", {30'b0, MemWrite}, 32'h0);
    chk("illegal_memread", {31'b0, MemREAD}, 32'h0);
    step(); chk("illegal_nop_pc", pc, 32'h74);
    step(); chk("jal_self_pc", pc, 32'h74); rchk("jal_x0", 0, 32'h0);
`endif

    rst = 1'b1;
    step();
    chk("midreset_pc", pc, 32'h0);
    rchk("midreset_x1", 1, 32'h0);
    rchk("midreset_x23", 23, 32'h0);
    rst = 1'b0;
    step();
    chk("restart_pc", pc, 32'h4);
    rchk("restart_x1", 1, 32'hA);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
